// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: sends one command/data byte to a 4-bit HD44780-style LCD bus.
// Each byte goes out as two nibbles, high nibble first. Every LCD pin is driven
// from a register. The setup, E-high, inter-nibble gap and execution waits are
// all timed from a single 20-bit cycle counter.
module lcd_byte_writer #(
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_E_HIGH    = 12,
    parameter int unsigned T_NIB_GAP   = 50,
    parameter int unsigned T_EXEC      = 2000,
    parameter int unsigned T_EXEC_LONG = 82000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       init_done,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_d
);

    localparam logic [19:0] LIM_SETUP = 20'(T_SETUP - 1);
    localparam logic [19:0] LIM_EHIGH = 20'(T_E_HIGH - 1);
    localparam logic [19:0] LIM_GAP   = 20'(T_NIB_GAP - 1);
    localparam logic [19:0] LIM_EXEC  = 20'(T_EXEC - 1);
    localparam logic [19:0] LIM_LONG  = 20'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP_H,
        EHI_H,
        GAP,
        SETUP_L,
        EHI_L,
        EXEC
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        rs_q, rs_d;
    logic [7:0]  data_q, data_d;
    logic        long_q, long_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic        lcd_e_q, lcd_e_d;
    logic [3:0]  lcd_d_q, lcd_d_d;
    logic [19:0] limit;
    logic        accept;

    assign wr_ready = (state_q == IDLE) && init_done;
    assign busy     = (state_q != IDLE);
    assign accept   = wr_valid && wr_ready;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_e    = lcd_e_q;
    assign lcd_d    = lcd_d_q;

    // State, counter, latched byte and registered LCD pins
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rs_q     <= 1'b0;
            data_q   <= '0;
            long_q   <= 1'b0;
            lcd_rs_q <= 1'b0;
            lcd_e_q  <= 1'b0;
            lcd_d_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_q     <= rs_d;
            data_q   <= data_d;
            long_q   <= long_d;
            lcd_rs_q <= lcd_rs_d;
            lcd_e_q  <= lcd_e_d;
            lcd_d_q  <= lcd_d_d;
        end
    end

    // Next-state sequencing, plus the next pin values derived from the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        long_d  = long_q;

        unique case (state_q)
            SETUP_H, SETUP_L: limit = LIM_SETUP;
            EHI_H, EHI_L:     limit = LIM_EHIGH;
            GAP:              limit = LIM_GAP;
            EXEC:             limit = long_q ? LIM_LONG : LIM_EXEC;
            default:          limit = '0;
        endcase

        if (state_q == IDLE) begin
            if (accept) begin
                rs_d    = wr_rs;
                data_d  = wr_data;
                long_d  = !wr_rs && (wr_data[7:2] == 6'd0) && (wr_data[1:0] != 2'd0);
                state_d = SETUP_H;
                cnt_d   = '0;
            end
        end else if (cnt_q == limit) begin
            cnt_d = '0;
            unique case (state_q)
                SETUP_H: state_d = EHI_H;
                EHI_H:   state_d = GAP;
                GAP:     state_d = SETUP_L;
                SETUP_L: state_d = EHI_L;
                EHI_L:   state_d = EXEC;
                default: state_d = IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + 20'd1;
        end

        // Pins are loaded only on entry into or stay in a setup state, so RS/D
        // can never move while E is high.
        lcd_e_d  = (state_d == EHI_H) || (state_d == EHI_L);
        lcd_rs_d = lcd_rs_q;
        lcd_d_d  = lcd_d_q;
        if (state_d == SETUP_H) begin
            lcd_rs_d = rs_d;
            lcd_d_d  = data_d[7:4];
        end else if (state_d == SETUP_L) begin
            lcd_d_d  = data_d[3:0];
        end
    end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// tb_lcd_byte_writer: directed bench for lcd_byte_writer. It checks nibble
// order, E timing, write latency, init_done gating, back-to-back writes and an
// asynchronous reset in the middle of a transfer.
module tb_lcd_byte_writer;

    // Shortened execution waits keep the long-command tests quick.
    localparam int unsigned T_EXEC      = 100;
    localparam int unsigned T_EXEC_LONG = 300;
    // 2*2 + 2*12 + 50 + exec
    localparam int unsigned N_NORM = 178;
    localparam int unsigned N_LONG = 378;
    // High-nibble E rises after setup; low-nibble E rises at 2+12+50+2.
    localparam int unsigned RISE1 = 2;
    localparam int unsigned RISE2 = 66;

    logic       clk_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_done = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, busy, lcd_rs, lcd_rw, lcd_e;
    logic [3:0] lcd_d;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned e_rises = 0;
    logic [3:0]  nibs[$];
    logic        mon_prev_e = 1'b0;
    logic        mon_prev_rs = 1'b0;
    logic [3:0]  mon_prev_d = 4'h0;

    lcd_byte_writer #(
        .T_SETUP    (2),
        .T_E_HIGH   (12),
        .T_NIB_GAP  (50),
        .T_EXEC     (T_EXEC),
        .T_EXEC_LONG(T_EXEC_LONG)
    ) dut (
        .clk_50   (clk_50),
        .rst_n    (rst_n),
        .init_done(init_done),
        .wr_valid (wr_valid),
        .wr_rs    (wr_rs),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_d    (lcd_d)
    );

    always #10 clk_50 = ~clk_50;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Per-cycle monitor: RS/D must hold while E is high, RW is always 0, and
    // every E rise is logged together with its nibble.
    always @(negedge clk_50) begin
        check_eq("rw_zero", {31'd0, lcd_rw}, 32'd0);
        if (mon_prev_e && lcd_e)
            check_eq("stable_rs_d", {27'd0, lcd_rs, lcd_d}, {27'd0, mon_prev_rs, mon_prev_d});
        if (lcd_e && !mon_prev_e) begin
            e_rises++;
            nibs.push_back(lcd_d);
        end
        mon_prev_e  = lcd_e;
        mon_prev_rs = lcd_rs;
        mon_prev_d  = lcd_d;
    end

    // One write with per-cycle timing measurement. Index 0 is the first
    // negedge after the accepting edge.
    task automatic do_write(input logic rs, input logic [7:0] data, input logic [3:0] exp_hi,
                            input logic [3:0] exp_lo, input int unsigned exp_n, input logic drop_init);
        int unsigned n = 0;
        int unsigned pulses = 0;
        int unsigned rise1 = 0;
        int unsigned rise2 = 0;
        int unsigned hi1 = 0;
        int unsigned hi2 = 0;
        logic [3:0]  d1 = 4'h0;
        logic [3:0]  d2 = 4'h0;
        logic        r1 = 1'b0;
        logic        r2 = 1'b0;
        logic        prev_e = 1'b0;
        @(negedge clk_50);
        init_done = 1'b1;
        wr_valid  = 1'b1;
        wr_rs     = rs;
        wr_data   = data;
        #1;
        check_eq("ready_before", {31'd0, wr_ready}, 32'd1);
        @(negedge clk_50);
        wr_valid = 1'b0;
        wr_rs    = ~rs;
        wr_data  = ~data;
        while (busy && n < exp_n + 100) begin
            if (lcd_e && !prev_e) begin
                pulses++;
                if (pulses == 1) begin rise1 = n; d1 = lcd_d; r1 = lcd_rs; end
                else if (pulses == 2) begin rise2 = n; d2 = lcd_d; r2 = lcd_rs; end
            end
            if (lcd_e) begin
                if (pulses == 1) hi1++;
                else hi2++;
            end
            if (drop_init && n == 5) init_done = 1'b0;
            prev_e = lcd_e;
            @(negedge clk_50);
            n++;
        end
        check_eq("latency", n, exp_n);
        check_eq("e_pulses", pulses, 2);
        check_eq("rise1", rise1, RISE1);
        check_eq("rise2", rise2, RISE2);
        check_eq("e_high1", hi1, 12);
        check_eq("e_high2", hi2, 12);
        check_eq("nib_hi", {28'd0, d1}, {28'd0, exp_hi});
        check_eq("nib_lo", {28'd0, d2}, {28'd0, exp_lo});
        check_eq("rs1", {31'd0, r1}, {31'd0, rs});
        check_eq("rs2", {31'd0, r2}, {31'd0, rs});
        check_eq("idle_hold", {27'd0, lcd_rs, lcd_d}, {27'd0, rs, exp_lo});
        check_eq("ready_after", {31'd0, wr_ready}, {31'd0, !drop_init});
    endtask

    task automatic wait_ready(output int unsigned n);
        n = 0;
        while (!wr_ready && n < N_LONG + 100) begin
            @(negedge clk_50);
            n++;
        end
    endtask

    initial begin
        int unsigned lat;
        logic        ready_seen;
        int unsigned rises_before;

        // Reset state
        repeat (2) @(posedge clk_50);
        #1;
        check_eq("rst_outs", {25'd0, busy, wr_ready, lcd_e, lcd_rs, lcd_d}, 32'd0);

        // init_done low gates acceptance even with a pending request
        @(negedge clk_50);
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h48;
        rst_n    = 1'b1;
        ready_seen = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk_50);
            if (wr_ready || busy) ready_seen = 1'b1;
        end
        check_eq("gated_ready", {31'd0, ready_seen}, 32'd0);
        check_eq("gated_e", e_rises, 0);

        // init_done rises with wr_valid high: accept on that same edge
        nibs.delete();
        do_write(1'b1, 8'h48, 4'h4, 4'h8, N_NORM, 1'b0);
        check_eq("nib_q_48", {24'd0, nibs[0], nibs[1]}, 32'h48);

        // Clear/home commands use the long wait; neighbours use the normal one
        do_write(1'b0, 8'h01, 4'h0, 4'h1, N_LONG, 1'b0);
        do_write(1'b0, 8'h02, 4'h0, 4'h2, N_LONG, 1'b0);
        do_write(1'b0, 8'h03, 4'h0, 4'h3, N_LONG, 1'b0);
        do_write(1'b0, 8'h04, 4'h0, 4'h4, N_NORM, 1'b0);
        do_write(1'b0, 8'h80, 4'h8, 4'h0, N_NORM, 1'b0);
        do_write(1'b0, 8'h00, 4'h0, 4'h0, N_NORM, 1'b0);
        do_write(1'b1, 8'h03, 4'h0, 4'h3, N_NORM, 1'b0);

        // init_done dropped during EHI_H: the transfer still completes
        do_write(1'b1, 8'hA5, 4'hA, 4'h5, N_NORM, 1'b1);

        // Back-to-back with wr_valid held high
        nibs.delete();
        @(negedge clk_50);
        init_done = 1'b1;
        wr_valid  = 1'b1;
        wr_rs     = 1'b1;
        wr_data   = 8'h41;
        @(negedge clk_50);
        wr_data = 8'h42;
        wait_ready(lat);
        check_eq("b2b_lat1", lat, N_NORM);
        @(negedge clk_50);
        check_eq("b2b_no_bubble", {31'd0, busy}, 32'd1);
        wr_valid = 1'b0;
        wait_ready(lat);
        check_eq("b2b_lat2", lat, N_NORM);
        check_eq("b2b_count", nibs.size(), 4);
        if (nibs.size() == 4)
            check_eq("b2b_nibs", {16'd0, nibs[0], nibs[1], nibs[2], nibs[3]}, 32'h4142);

        // Asynchronous reset during EHI_L
        @(negedge clk_50);
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = 8'h7E;
        @(negedge clk_50);
        wr_valid = 1'b0;
        repeat (70) @(negedge clk_50);
        check_eq("pre_rst_e", {27'd0, lcd_e, lcd_d}, 32'h1E);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_outs", {26'd0, busy, lcd_e, lcd_rs, lcd_d}, 32'd0);
        repeat (3) @(negedge clk_50);
        rst_n = 1'b1;
        rises_before = e_rises;
        repeat (200) @(negedge clk_50);
        check_eq("post_rst_no_e", e_rises, rises_before);
        check_eq("post_rst_ready", {30'd0, wr_ready, busy}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
